// File: rtl/disp_pkg.sv
// Shared types for the display read-channel arbiter: port ids, default tag depth, AR FSM states.
package disp_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_S0 = 1'b0;
    localparam port_id_t PORT_S1 = 1'b1;

    localparam int C_OUTSTANDING_DEF = 4;

    typedef enum logic [0:0] {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_e;

endpackage

// File: rtl/disp_rd_arbiter_if.sv
// Bundle of requester-side AR/R signals, master-side AR/R signals and status for disp_rd_arbiter.
interface disp_rd_arbiter_if #(
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_OUTSTANDING      = 4
);
    localparam int CNT_W = $clog2(C_OUTSTANDING) + 1;

    logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR, S1_ARADDR;
    logic [7:0]                    S0_ARLEN, S1_ARLEN;
    logic                          S0_ARVALID, S1_ARVALID;
    logic                          S0_ARREADY, S1_ARREADY;
    logic                          S0_RVALID, S1_RVALID;
    logic                          S0_RREADY, S1_RREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] S_RDATA;
    logic                          S_RLAST;

    logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR;
    logic [7:0]                    M_ARLEN;
    logic                          M_ARVALID, M_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_RDATA;
    logic                          M_RLAST, M_RVALID, M_RREADY;

    logic [CNT_W-1:0]              OUTSTANDING;
    logic                          R_ORPHAN;

    // The arbiter is the AXI master towards memory; "slave" is everything around it.
    modport master (
        input  S0_ARADDR, S1_ARADDR, S0_ARLEN, S1_ARLEN, S0_ARVALID, S1_ARVALID,
        input  S0_RREADY, S1_RREADY, M_ARREADY, M_RDATA, M_RLAST, M_RVALID,
        output S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID, S_RDATA, S_RLAST,
        output M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY, OUTSTANDING, R_ORPHAN
    );

    modport slave (
        output S0_ARADDR, S1_ARADDR, S0_ARLEN, S1_ARLEN, S0_ARVALID, S1_ARVALID,
        output S0_RREADY, S1_RREADY, M_ARREADY, M_RDATA, M_RLAST, M_RVALID,
        input  S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID, S_RDATA, S_RLAST,
        input  M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY, OUTSTANDING, R_ORPHAN
    );

endinterface

// File: rtl/disp_tag_fifo.sv
// Burst-owner tag FIFO: 1-bit port ids in issue order, power-of-two depth, async active-low reset.
module disp_tag_fifo
    import disp_pkg::*;
#(
    parameter int DEPTH = C_OUTSTANDING_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  port_id_t                 din_i,
    input  logic                     pop_i,
    output port_id_t                 dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    port_id_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/disp_rd_arbiter.sv
// Two-port AXI read arbiter sharing the display master read port; R beats steered by an owner tag FIFO.
// Define DISP_RD_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module disp_rd_arbiter
    import disp_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_OUTSTANDING      = C_OUTSTANDING_DEF
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    disp_rd_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(C_OUTSTANDING) + 1;

    localparam logic [0:0] ST_IDLE  = 1'(AR_IDLE);
    localparam logic [0:0] ST_ISSUE = 1'(AR_ISSUE);

    logic [0:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic                          orphan_q, orphan_d;

    port_id_t                      winner, head;
    logic                          any_req, grant, pop;
    logic                          fifo_full, fifo_empty;
    logic [CNT_W-1:0]              count;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata;

    assign any_req = bus.S0_ARVALID | bus.S1_ARVALID;
    assign grant   = (state_q == ST_IDLE) & ~fifo_full & any_req;

`ifdef DISP_RD_ARB_RR_EN
    port_id_t rr_q, rr_d;

    // rr_q names the port that wins a tie; it flips to the loser after every grant.
    always_comb begin
        if (bus.S0_ARVALID && bus.S1_ARVALID) winner = rr_q;
        else if (bus.S1_ARVALID)              winner = PORT_S1;
        else                                  winner = PORT_S0;
        rr_d = rr_q;
        if (grant) rr_d = ~winner;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rr_q <= PORT_S0;
        else          rr_q <= rr_d;
    end
`else
    always_comb begin
        winner = bus.S0_ARVALID ? PORT_S0 : PORT_S1;
    end
`endif

    assign bus.S0_ARREADY = grant & (winner == PORT_S0);
    assign bus.S1_ARREADY = grant & (winner == PORT_S1);

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d  = ST_ISSUE;
                    araddr_d = (winner == PORT_S1) ? bus.S1_ARADDR : bus.S0_ARADDR;
                    arlen_d  = (winner == PORT_S1) ? bus.S1_ARLEN  : bus.S0_ARLEN;
                end
            end
            default: begin
                if (bus.M_ARREADY) state_d = ST_IDLE;
            end
        endcase
    end

    // AR address/length stay reset to zero so the master port is quiet out of reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            orphan_q <= orphan_d;
        end
    end

    assign bus.M_ARVALID = (state_q == ST_ISSUE);
    assign bus.M_ARADDR  = araddr_q;
    assign bus.M_ARLEN   = arlen_q;

    // R steering is purely combinational; an empty tag FIFO blocks the beat entirely.
    assign bus.S0_RVALID = bus.M_RVALID & ~fifo_empty & (head == PORT_S0);
    assign bus.S1_RVALID = bus.M_RVALID & ~fifo_empty & (head == PORT_S1);
    assign bus.M_RREADY  = ~fifo_empty & ((head == PORT_S1) ? bus.S1_RREADY : bus.S0_RREADY);
    assign pop           = bus.M_RVALID & bus.M_RREADY & bus.M_RLAST;

    assign rdata       = bus.M_RDATA;
    assign bus.S_RDATA = rdata;
    assign bus.S_RLAST = bus.M_RLAST;

    assign orphan_d     = orphan_q | (bus.M_RVALID & fifo_empty);
    assign bus.R_ORPHAN = orphan_q;

    assign bus.OUTSTANDING = count;

    disp_tag_fifo #(
        .DEPTH (C_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .push_i  (grant),
        .din_i   (winner),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

endmodule
